// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake bundle for uart_tx_fifo: producer drives valid/data,
// the transmitter answers with ready.
interface uart_tx_fifo_if #(
  parameter int DATA_W = 16
) ();
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with transmit FIFO and runtime frame format.
// Define UART_TX_CTS_EN to add the cts_n flow-control input.
module uart_tx_fifo #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIV_W-1:0]              cfg_clk_div,
  input  logic [4:0]                    cfg_bits,
  input  logic                          cfg_parity_en,
  input  logic                          cfg_parity_odd,
  input  logic                          cfg_two_stop,
  uart_tx_fifo_if.slave                 wr,
`ifdef UART_TX_CTS_EN
  input  logic                          cts_n,
`endif
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam int NB_W = $clog2(DATA_W + 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP1  = 3'd4;
  localparam logic [2:0] ST_STOP2  = 3'd5;

  // Effective data-bit count: 0 means 1, anything above DATA_W saturates.
  function automatic logic [NB_W-1:0] clamp_bits(input logic [4:0] b);
    logic [NB_W-1:0] r;
    if (b == 5'd0) begin
      r = NB_W'(1);
    end else if (int'(b) > DATA_W) begin
      r = NB_W'(DATA_W);
    end else begin
      r = NB_W'(b);
    end
    return r;
  endfunction

  function automatic logic frame_parity(input logic [DATA_W-1:0] word,
                                        input logic [NB_W-1:0]   nb,
                                        input logic              odd);
    logic p;
    p = odd;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < int'(nb)) begin
        p = p ^ word[i];
      end else begin
        p = p;
      end
    end
    return p;
  endfunction

  logic [2:0]        state_q, state_d, state_n;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [NB_W-1:0]   bit_q, bit_d, bit_n;
  logic [NB_W-1:0]   nbits_q, nbits_d;
  logic [DATA_W-1:0] shift_q, shift_d, shift_n;
  logic              par_q, par_d;
  logic              par_en_q, par_en_d;
  logic              two_stop_q, two_stop_d;
  logic [LW-1:0]     level_q, level_d;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] head;
  logic              push, pop, bit_end, last_bit, can_start, start_ok;

`ifdef UART_TX_CTS_EN
  logic cts_meta_q, cts_sync_q;

  // Two-flop synchronizer; reset to "not clear" so nothing starts early.
  always_ff @(posedge clk) begin
    if (rst) begin
      cts_meta_q <= 1'b1;
      cts_sync_q <= 1'b1;
    end else begin
      cts_meta_q <= cts_n;
      cts_sync_q <= cts_meta_q;
    end
  end
  assign start_ok = ~cts_sync_q;
`else
  assign start_ok = 1'b1;
`endif

  assign head      = mem_q[rptr_q];
  assign push      = wr.wr_valid && ready_q;
  assign bit_end   = (cnt_q == div_q);
  assign last_bit  = (bit_q == nbits_q - NB_W'(1));
  assign can_start = (level_q != {LW{1'b0}}) && start_ok;

  // Frame sequencing; a pop at the end of a stop bit chains straight into START.
  always_comb begin
    state_n = state_q;
    shift_n = shift_q;
    bit_n   = bit_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE:   pop = can_start;
      ST_START:  state_n = bit_end ? ST_DATA : ST_START;
      ST_DATA: begin
        if (bit_end) begin
          shift_n = shift_q >> 1'b1;
          if (last_bit) begin
            bit_n   = {NB_W{1'b0}};
            state_n = par_en_q ? ST_PARITY : ST_STOP1;
          end else begin
            bit_n   = bit_q + NB_W'(1);
            state_n = ST_DATA;
          end
        end else begin
          state_n = ST_DATA;
        end
      end
      ST_PARITY: state_n = bit_end ? ST_STOP1 : ST_PARITY;
      ST_STOP1: begin
        if (bit_end && two_stop_q) begin
          state_n = ST_STOP2;
        end else if (bit_end) begin
          pop     = can_start;
          state_n = ST_IDLE;
        end else begin
          state_n = ST_STOP1;
        end
      end
      ST_STOP2: begin
        if (bit_end) begin
          pop     = can_start;
          state_n = ST_IDLE;
        end else begin
          state_n = ST_STOP2;
        end
      end
      default:   state_n = ST_IDLE;
    endcase

    state_d    = pop ? ST_START : state_n;
    shift_d    = pop ? head : shift_n;
    bit_d      = pop ? {NB_W{1'b0}} : bit_n;
    div_d      = pop ? cfg_clk_div : div_q;
    nbits_d    = pop ? clamp_bits(cfg_bits) : nbits_q;
    par_en_d   = pop ? cfg_parity_en : par_en_q;
    two_stop_d = pop ? cfg_two_stop : two_stop_q;
    par_d      = pop ? frame_parity(head, clamp_bits(cfg_bits), cfg_parity_odd) : par_q;
    cnt_d      = (pop || (state_q == ST_IDLE) || bit_end) ? {DIV_W{1'b0}}
                                                          : cnt_q + DIV_W'(1);
  end

  // FIFO bookkeeping and registered outputs derived from next-state values.
  always_comb begin
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
    ready_d = (level_d != LW'(FIFO_DEPTH));
    busy_d  = (state_d != ST_IDLE) || (level_d != {LW{1'b0}});
    case (state_q)
      ST_IDLE:   tx_d = 1'b1;
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_q[0];
      ST_PARITY: tx_d = par_q;
      ST_STOP1:  tx_d = 1'b1;
      ST_STOP2:  tx_d = 1'b1;
      default:   tx_d = 1'b1;
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {DIV_W{1'b0}};
      div_q      <= {DIV_W{1'b0}};
      bit_q      <= {NB_W{1'b0}};
      nbits_q    <= NB_W'(1);
      shift_q    <= {DATA_W{1'b0}};
      par_q      <= 1'b0;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
      level_q    <= {LW{1'b0}};
      wptr_q     <= {AW{1'b0}};
      rptr_q     <= {AW{1'b0}};
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      nbits_q    <= nbits_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      par_en_q   <= par_en_d;
      two_stop_q <= two_stop_d;
      level_q    <= level_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
    end
  end

  // FIFO storage is not cleared; the pointers define validity.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wptr_q] <= wr.wr_data;
    end
  end

  assign wr.wr_ready = ready_q;
  assign tx          = tx_q;
  assign busy        = busy_q;
  assign fifo_level  = level_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: table of single frames plus FIFO, reset,
// config-change and (with UART_TX_CTS_EN) flow-control sequences.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cfg_clk_div;
  logic [4:0]  cfg_bits;
  logic        cfg_parity_en, cfg_parity_odd, cfg_two_stop;
  logic        tx, busy;
  logic [4:0]  fifo_level;
`ifdef UART_TX_CTS_EN
  logic        cts_n = 1'b0;
`endif

  uart_tx_fifo_if #(.DATA_W(16)) wr_if ();

  uart_tx_fifo #(.DATA_W(16), .FIFO_DEPTH(16), .DIV_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_clk_div    (cfg_clk_div),
    .cfg_bits       (cfg_bits),
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_odd (cfg_parity_odd),
    .cfg_two_stop   (cfg_two_stop),
    .wr             (wr_if),
`ifdef UART_TX_CTS_EN
    .cts_n          (cts_n),
`endif
    .tx             (tx),
    .busy           (busy),
    .fifo_level     (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic tx; logic busy; } samp_t;

  typedef struct {
    logic [15:0] data;
    logic [4:0]  bits;
    logic        par_en;
    logic        par_odd;
    logic        two_stop;
    logic [15:0] div;
    logic [31:0] exp_frame;  // bit k = k-th bit on the line, start bit first
    int          exp_len;
  } vec_t;

  vec_t  vecs [7];
  samp_t rec_q [$];
  samp_t exp_q [$];
  bit    rec_en = 1'b0;
  int    n_checks = 0;
  int    n_errors = 0;

  always begin
    @(posedge clk);
    #1;
    if (rec_en) begin
      samp_t s;
      s.tx   = tx;
      s.busy = busy;
      rec_q.push_back(s);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [15:0] div, input logic [4:0] bits,
                         input logic pe, input logic po, input logic ts);
    cfg_clk_div    = div;
    cfg_bits       = bits;
    cfg_parity_en  = pe;
    cfg_parity_odd = po;
    cfg_two_stop   = ts;
  endtask

  task automatic push_word(input logic [15:0] d, output int waited);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = d;
    waited = 0;
    while (wr_if.wr_ready !== 1'b1 && waited < 100) begin
      tick();
      waited++;
    end
    tick();
    check("push_accepted", 32'(waited < 100), 32'd1);
  endtask

  // Reference frame builder for the multi-frame sequences.
  task automatic make_frame(input logic [15:0] d, input int bits, input logic pe,
                            input logic po, input logic ts,
                            output logic [31:0] fr, output int len);
    int   nb;
    logic p;
    nb  = (bits == 0) ? 1 : ((bits > 16) ? 16 : bits);
    fr  = 32'd0;
    len = 1;
    p   = po;
    for (int i = 0; i < nb; i++) begin
      fr[len] = d[i];
      p       = p ^ d[i];
      len++;
    end
    if (pe) begin
      fr[len] = p;
      len++;
    end
    fr[len] = 1'b1;
    len++;
    if (ts) begin
      fr[len] = 1'b1;
      len++;
    end
  endtask

  // Sample 0 is the write edge, sample 1 the pop edge; the line stays high.
  task automatic exp_begin();
    samp_t s;
    rec_q.delete();
    exp_q.delete();
    s.tx = 1'b1;
    s.busy = 1'b1;
    exp_q.push_back(s);
    exp_q.push_back(s);
  endtask

  task automatic exp_add(input logic [31:0] fr, input int len, input int b);
    samp_t s;
    for (int k = 0; k < len; k++) begin
      for (int c = 0; c < b; c++) begin
        s.tx   = fr[k];
        s.busy = 1'b1;
        exp_q.push_back(s);
      end
    end
  endtask

  // busy drops on the edge that ends the last stop bit; one idle sample follows.
  task automatic exp_end();
    samp_t s;
    s = exp_q[exp_q.size() - 1];
    s.busy = 1'b0;
    exp_q[exp_q.size() - 1] = s;
    s.tx = 1'b1;
    exp_q.push_back(s);
  endtask

  task automatic start_rec();
    #1;
    rec_en = 1'b1;
  endtask

  task automatic run_compare(input string name);
    int g;
    g = 0;
    while (rec_q.size() < exp_q.size() && g < 5000) begin
      @(posedge clk);
      #2;
      g++;
    end
    rec_en = 1'b0;
    check($sformatf("%s_len", name), 32'(rec_q.size() >= exp_q.size()), 32'd1);
    for (int i = 0; i < exp_q.size() && i < rec_q.size(); i++) begin
      check($sformatf("%s[%0d]{tx,busy}", name, i), 32'(rec_q[i]), 32'(exp_q[i]));
    end
  endtask

  initial begin
    int          w;
    int          len;
    int          zeros;
    logic [31:0] fr;
    logic [15:0] word;
    bit          bad;

    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          w;
    int          len;
    int          cnt;
    logic [31:0] fr;
    logic [15:0] word;
    bit          bad;

    vecs[0] = '{16'h0055, 5'd8,  1'b0, 1'b0, 1'b0, 16'd3, 32'h0000_02AA, 10};
    vecs[1] = '{16'h0003, 5'd7,  1'b1, 1'b0, 1'b1, 16'd1, 32'h0000_0606, 11};
    vecs[2] = '{16'h0003, 5'd7,  1'b1, 1'b1, 1'b0, 16'd2, 32'h0000_0306, 10};
    vecs[3] = '{16'h00A5, 5'd0,  1'b0, 1'b0, 1'b0, 16'd0, 32'h0000_0006, 3};
    vecs[4] = '{16'hFFFF, 5'd31, 1'b1, 1'b1, 1'b0, 16'd1, 32'h0007_FFFE, 19};
    vecs[5] = '{16'h1234, 5'd5,  1'b1, 1'b0, 1'b1, 16'd0, 32'h0000_01A8, 9};
    vecs[6] = '{16'h0000, 5'd8,  1'b1, 1'b1, 1'b0, 16'd2, 32'h0000_0600, 11};

    rst = 1'b1;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_data  = 16'h0000;
    set_cfg(16'd3, 5'd8, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ready", 32'(wr_if.wr_ready), 32'd1);
    check("reset_level", 32'(fifo_level), 32'd0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 7; v++) begin
      set_cfg(vecs[v].div, vecs[v].bits, vecs[v].par_en, vecs[v].par_odd, vecs[v].two_stop);
      exp_begin();
      exp_add(vecs[v].exp_frame, vecs[v].exp_len, int'(vecs[v].div) + 1);
      exp_end();
      start_rec();
      push_word(vecs[v].data, w);
      wr_if.wr_valid = 1'b0;
      run_compare($sformatf("vec%0d", v));
    end

    // Fill: with div=0 the FIFO reaches 16 after 18 writes (pops at writes 2 and 12).
    set_cfg(16'd0, 5'd8, 1'b0, 1'b0, 1'b0);
    exp_begin();
    for (int f = 0; f < 19; f++) begin
      word = 16'(f) * 16'd29 + 16'd17;
      make_frame(word, 8, 1'b0, 1'b0, 1'b0, fr, len);
      exp_add(fr, len, 1);
    end
    exp_end();
    start_rec();
    for (int f = 0; f < 18; f++) begin
      push_word(16'(f) * 16'd29 + 16'd17, w);
    end
    check("fill_level", 32'(fifo_level), 32'd16);
    check("fill_ready", 32'(wr_if.wr_ready), 32'd0);
    push_word(16'd18 * 16'd29 + 16'd17, w);
    check("fill_blocked_cycles", 32'(w), 32'd4);
    check("fill_level_after", 32'(fifo_level), 32'd16);
    wr_if.wr_valid = 1'b0;
    run_compare("fifo");

    // Format change during a frame only affects the next frame.
    set_cfg(16'd1, 5'd8, 1'b0, 1'b0, 1'b0);
    exp_begin();
    make_frame(16'h00E0, 8, 1'b0, 1'b0, 1'b0, fr, len);
    exp_add(fr, len, 2);
    make_frame(16'h00E0, 5, 1'b0, 1'b0, 1'b0, fr, len);
    exp_add(fr, len, 2);
    exp_end();
    start_rec();
    push_word(16'h00E0, w);
    push_word(16'h00E0, w);
    wr_if.wr_valid = 1'b0;
    tick();
    tick();
    cfg_bits = 5'd5;
    run_compare("cfgchg");

    // Reset in the middle of DATA with three words queued.
    set_cfg(16'd3, 5'd8, 1'b0, 1'b0, 1'b0);
    push_word(16'h0000, w);
    push_word(16'h0011, w);
    push_word(16'h0022, w);
    push_word(16'h0033, w);
    wr_if.wr_valid = 1'b0;
    check("rstmid_level", 32'(fifo_level), 32'd3);
    repeat (6) tick();
    check("rstmid_tx_data", 32'(tx), 32'd0);
    rst = 1'b1;
    tick();
    check("rstmid_tx", 32'(tx), 32'd1);
    check("rstmid_level0", 32'(fifo_level), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_ready", 32'(wr_if.wr_ready), 32'd1);
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    check("rstmid_quiet", 32'(bad), 32'd0);

`ifdef UART_TX_CTS_EN
    // Held off: words wait; once released a started frame always completes.
    set_cfg(16'd1, 5'd8, 1'b0, 1'b0, 1'b0);
    cts_n = 1'b1;
    repeat (3) tick();
    push_word(16'h000F, w);
    push_word(16'h000F, w);
    wr_if.wr_valid = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx !== 1'b1) bad = 1'b1;
    end
    check("cts_hold_tx", 32'(bad), 32'd0);
    check("cts_hold_level", 32'(fifo_level), 32'd2);
    check("cts_hold_busy", 32'(busy), 32'd1);
    cts_n = 1'b0;
    cnt = 0;
    while (tx === 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
    check("cts_start_latency", 32'(cnt <= 5), 32'd1);
    cts_n = 1'b1;
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (tx === 1'b0) cnt++;
    end
    check("cts_frame_zero_cycles", 32'(cnt), 32'd10);
    check("cts_second_held", 32'(fifo_level), 32'd1);
    check("cts_busy_held", 32'(busy), 32'd1);
    cts_n = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
    check("cts_drain", 32'(busy), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
